// File: rtl/ncl_pkg.sv
// rtl/ncl_pkg.sv - NCL dual-rail digit codes, controller states and wavefront helpers
package ncl_pkg;

  localparam logic [1:0] NCL_NULL = 2'b00;
  localparam logic [1:0] NCL_D0   = 2'b01;
  localparam logic [1:0] NCL_D1   = 2'b10;
  localparam logic [1:0] NCL_ILL  = 2'b11;

  // Helpers take a zero-extended digit vector plus the count of live digits.
  localparam int NCL_MAX_DIGITS = 128;

  typedef enum logic [1:0] {S_NULL, S_CALC, S_PEND, S_DATA} ncl_state_e;

  function automatic logic is_complete(input logic [2*NCL_MAX_DIGITS-1:0] vec, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NCL_MAX_DIGITS; i++) begin
      if (i < n && !(vec[2*i +: 2] == NCL_D0 || vec[2*i +: 2] == NCL_D1)) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic is_null(input logic [2*NCL_MAX_DIGITS-1:0] vec, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NCL_MAX_DIGITS; i++) begin
      if (i < n && vec[2*i +: 2] != NCL_NULL) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic has_illegal(input logic [2*NCL_MAX_DIGITS-1:0] vec, input int n);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NCL_MAX_DIGITS; i++) begin
      if (i < n && vec[2*i +: 2] == NCL_ILL) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/ncl_minterm_digit.sv
// rtl/ncl_minterm_digit.sv - combinational one-digit dual-rail minterm full adder
module ncl_minterm_digit
  import ncl_pkg::*;
(
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  input  logic [1:0] c_i,
  output logic [1:0] s_o,
  output logic [1:0] c_o
);

  // m[k] fires for the input combination {a,b,c} == k; NULL inputs fire none.
  logic [7:0] m;

  assign m[0] = a_i[0] & b_i[0] & c_i[0];
  assign m[1] = a_i[0] & b_i[0] & c_i[1];
  assign m[2] = a_i[0] & b_i[1] & c_i[0];
  assign m[3] = a_i[0] & b_i[1] & c_i[1];
  assign m[4] = a_i[1] & b_i[0] & c_i[0];
  assign m[5] = a_i[1] & b_i[0] & c_i[1];
  assign m[6] = a_i[1] & b_i[1] & c_i[0];
  assign m[7] = a_i[1] & b_i[1] & c_i[1];

  assign s_o = {m[1] | m[2] | m[4] | m[7], m[0] | m[3] | m[5] | m[6]};
  assign c_o = {m[3] | m[5] | m[6] | m[7], m[0] | m[1] | m[2] | m[4]};

endmodule

// File: rtl/ncl_serial_adder.sv
// rtl/ncl_serial_adder.sv - clocked digit-serial dual-rail adder with ki/ko handshake; NCL_ILLEGAL_CHECK_EN adds sticky err
module ncl_serial_adder
  import ncl_pkg::*;
#(
  parameter int DIGITS           = 8,
  parameter int DIGITS_PER_CYCLE = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*DIGITS-1:0] a,
  input  logic [2*DIGITS-1:0] b,
  input  logic [1:0]          cin,
  input  logic                ki,
  output logic                ko,
  output logic [2*DIGITS-1:0] sum,
  output logic [1:0]          cout,
  output logic                err
);

  localparam int G    = (DIGITS_PER_CYCLE < 1) ? 1 : DIGITS_PER_CYCLE;
  localparam int NCYC = DIGITS / G;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int NIN  = 2 * DIGITS + 1;

  if (DIGITS < 1 || DIGITS_PER_CYCLE < 1 || (DIGITS % G) != 0 || NIN > NCL_MAX_DIGITS) begin : g_bad_params
    $error("ncl_serial_adder: DIGITS must be >=1 and a multiple of DIGITS_PER_CYCLE");
  end

  ncl_state_e                  state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [NCYC-1:0][2*G-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]                  carry_q, carry_d;
  logic [G:0][1:0]             carry_chain;
  logic [2*G-1:0]              slice_sum;
  logic [2*NCL_MAX_DIGITS-1:0] in_vec;
  logic                        in_complete, in_null;

  assign in_vec      = {{(2*NCL_MAX_DIGITS-2*NIN){1'b0}}, a, b, cin};
  assign in_complete = is_complete(in_vec, NIN);
  assign in_null     = is_null(in_vec, NIN);

  // One slice of G digits per cycle, rippling from the registered carry.
  assign carry_chain[0] = carry_q;
  for (genvar g = 0; g < G; g++) begin : g_slice
    ncl_minterm_digit u_digit (
      .a_i (a_q[cnt_q][2*g +: 2]),
      .b_i (b_q[cnt_q][2*g +: 2]),
      .c_i (carry_chain[g]),
      .s_o (slice_sum[2*g +: 2]),
      .c_o (carry_chain[g+1])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    case (state_q)
      S_NULL: begin
        if (in_complete) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        res_d[cnt_q] = slice_sum;
        carry_d      = carry_chain[G];
        if (cnt_q == CW'(NCYC - 1)) begin
          cnt_d   = '0;
          state_d = S_PEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PEND: begin
        if (ki) state_d = S_DATA;
      end
      S_DATA: begin
        if (!ki && in_null) begin
          res_d   = '0;
          carry_d = NCL_NULL;
          state_d = S_NULL;
        end
      end
      default: state_d = S_NULL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_NULL;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= NCL_NULL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end

  // Results stay hidden until the whole word is resolved, so outputs never mix NULL and DATA.
  assign ko   = (state_q == S_NULL);
  assign sum  = (state_q == S_DATA) ? res_q : '0;
  assign cout = (state_q == S_DATA) ? carry_q : NCL_NULL;

`ifdef NCL_ILLEGAL_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (has_illegal(in_vec, NIN)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ncl_serial_adder.sv
// tb/tb_ncl_serial_adder.sv - self-checking bench for ncl_serial_adder (DIGITS=8, G=2)
module tb_ncl_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic [1:0]  cin;
  logic        ki;
  logic        ko;
  logic [15:0] sum;
  logic [1:0]  cout;
  logic        err;

  int checks = 0;
  int errors = 0;

  ncl_serial_adder #(.DIGITS(8), .DIGITS_PER_CYCLE(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .ki   (ki),
    .ko   (ko),
    .sum  (sum),
    .cout (cout),
    .err  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    int         kdelay;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  function automatic logic [15:0] dr8(input logic [7:0] v);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic [1:0] dr1(input logic v);
    return v ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Full wavefront cycle: present DATA, wait out compute and optional ki hold-off, then return to NULL.
  task automatic op(input logic [7:0] va, input logic [7:0] vb, input logic ci, input int kdelay,
                    input logic [7:0] es, input logic ec, input logic scramble, input logic stay);
    int got;
    int exp_edge;
    @(negedge clk);
    a = dr8(va); b = dr8(vb); cin = dr1(ci); ki = (kdelay == 0);
    @(posedge clk); #1;
    chk("ko_fall", 32'(ko), 32'd0);
    if (scramble) begin
      @(negedge clk);
      a = dr8(8'($urandom)); b = dr8(8'($urandom)); cin = dr1(1'($urandom));
    end
    exp_edge = 5 + kdelay;
    got = 0;
    for (int e = 1; e <= exp_edge + 4; e++) begin
      @(posedge clk); #1;
      if (sum !== 16'h0 || cout !== 2'b00) begin
        got = e;
        break;
      end
      if (kdelay > 0 && e == 4 + kdelay) begin
        @(negedge clk);
        ki = 1'b1;
      end
    end
    chk("latency", 32'(got), 32'(exp_edge));
    chk("sum", 32'(sum), 32'(dr8(es)));
    chk("cout", 32'(cout), 32'(dr1(ec)));
    chk("ko_data", 32'(ko), 32'd0);
    if (stay) begin
      @(negedge clk); ki = 1'b0;
      @(posedge clk); #1;
      chk("stay_ki0_sum", 32'(sum), 32'(dr8(es)));
      chk("stay_ki0_ko", 32'(ko), 32'd0);
      @(negedge clk); ki = 1'b1; a = '0; b = '0; cin = '0;
      @(posedge clk); #1;
      chk("stay_null_sum", 32'(sum), 32'(dr8(es)));
    end
    @(negedge clk);
    a = '0; b = '0; cin = '0; ki = 1'b0;
    @(posedge clk); #1;
    chk("sum_null", 32'(sum), 32'd0);
    chk("cout_null", 32'(cout), 32'd0);
    chk("ko_rise", 32'(ko), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] model;
    logic [15:0] partial;

    tbl[0] = '{8'hA5, 8'h3C, 1'b0, 0, 8'hE1, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b1, 0, 8'h01, 1'b1};
    tbl[2] = '{8'h00, 8'h00, 1'b0, 0, 8'h00, 1'b0};
    tbl[3] = '{8'hFF, 8'hFF, 1'b1, 2, 8'hFF, 1'b1};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 0, 8'h00, 1'b1};
    tbl[5] = '{8'h12, 8'h34, 1'b1, 3, 8'h47, 1'b0};

    rst = 1'b1; a = '0; b = '0; cin = '0; ki = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ko", 32'(ko), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    repeat (5) @(posedge clk); #1;
    chk("idle_ko", 32'(ko), 32'd1);
    chk("idle_sum", 32'(sum), 32'd0);

    for (int i = 0; i < 6; i++)
      op(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].kdelay, tbl[i].exp_sum, tbl[i].exp_cout, 1'b0, i == 0);

    // Partial wavefront: digit 3 of A left NULL.
    @(negedge clk);
    partial = dr8(8'h5A);
    partial[7:6] = 2'b00;
    a = partial; b = dr8(8'h0F); cin = dr1(1'b0); ki = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("partial_ko", 32'(ko), 32'd1);
    end
    op(8'h5A, 8'h0F, 1'b0, 0, 8'h69, 1'b0, 1'b0, 1'b0);

    // Reset during compute.
    @(negedge clk);
    a = dr8(8'h33); b = dr8(8'h44); cin = dr1(1'b0); ki = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ko_fall", 32'(ko), 32'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b1; a = '0; b = '0; cin = '0;
    @(posedge clk); #1;
    chk("midrst_ko", 32'(ko), 32'd1);
    chk("midrst_sum", 32'(sum), 32'd0);
    @(negedge clk); rst = 1'b0;
    op(8'h33, 8'h44, 1'b1, 0, 8'h78, 1'b0, 1'b0, 1'b0);

    // Randomized against arithmetic reference, inputs scrambled during compute.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      model = 9'(ra) + 9'(rb) + 9'(rc);
      op(ra, rb, rc, int'($urandom_range(0, 3)), model[7:0], model[8], 1'b1, 1'b0);
    end

    // Illegal digit on b.
    @(negedge clk);
    a = dr8(8'h01); b = dr8(8'h02); b[1:0] = 2'b11; cin = dr1(1'b0); ki = 1'b1;
    @(posedge clk); #1;
    chk("ill_no_capture", 32'(ko), 32'd1);
`ifdef NCL_ILLEGAL_CHECK_EN
    chk("ill_err_set", 32'(err), 32'd1);
`else
    chk("ill_err_tied", 32'(err), 32'd0);
`endif
    @(negedge clk); a = '0; b = '0; cin = '0;
    repeat (3) @(posedge clk); #1;
`ifdef NCL_ILLEGAL_CHECK_EN
    chk("ill_err_sticky", 32'(err), 32'd1);
`else
    chk("ill_err_tied2", 32'(err), 32'd0);
`endif
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("ill_err_cleared", 32'(err), 32'd0);
    chk("ill_ko_after_rst", 32'(ko), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
